// File: rtl/id_operand_stage.sv
// Decode-stage operand fetch: regfile addressing, EX/MEM/WB bypass selection,
// load-use stall detection and a valid/ready output register feeding EX.

module id_operand_resolve #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic [AW-1:0] r,
   input  logic [DW-1:0] rf_rdata,
   input  logic          ex_fwd_valid,
   input  logic [AW-1:0] ex_fwd_addr,
   input  logic          ex_fwd_ok,
   input  logic [DW-1:0] ex_fwd_data,
   input  logic          mem_fwd_valid,
   input  logic [AW-1:0] mem_fwd_addr,
   input  logic          mem_fwd_ok,
   input  logic [DW-1:0] mem_fwd_data,
   input  logic          wb_we,
   input  logic [AW-1:0] wb_waddr,
   input  logic [DW-1:0] wb_wdata,
   output logic [DW-1:0] val,
   output logic          hz
);
   // Youngest match wins; a not-yet-ready younger producer stalls even if an
   // older stage already holds a value for the same register.
   always_comb begin
      val = rf_rdata;
      hz  = 1'b0;
      if (r == '0) begin
         val = '0;
      end else if (ex_fwd_valid && ex_fwd_addr == r) begin
         val = ex_fwd_data;
         hz  = !ex_fwd_ok;
      end else if (mem_fwd_valid && mem_fwd_addr == r) begin
         val = mem_fwd_data;
         hz  = !mem_fwd_ok;
      end else if (wb_we && wb_waddr == r) begin
         val = wb_wdata;
      end
   end
endmodule

module id_operand_stage #(
   parameter int DW  = 32,
   parameter int AW  = 5,
   parameter int SCW = 32   // stall counter width, saturates at all-ones
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_pc,
   input  logic [AW-1:0] in_rs,
   input  logic [AW-1:0] in_rt,
   input  logic          in_use_rs,
   input  logic          in_use_rt,
   input  logic [AW-1:0] in_dest,
   output logic [AW-1:0] rf_raddr1,
   output logic [AW-1:0] rf_raddr2,
   input  logic [DW-1:0] rf_rdata1,
   input  logic [DW-1:0] rf_rdata2,
   input  logic          ex_fwd_valid,
   input  logic [AW-1:0] ex_fwd_addr,
   input  logic          ex_fwd_ok,
   input  logic [DW-1:0] ex_fwd_data,
   input  logic          mem_fwd_valid,
   input  logic [AW-1:0] mem_fwd_addr,
   input  logic          mem_fwd_ok,
   input  logic [DW-1:0] mem_fwd_data,
   input  logic          wb_we,
   input  logic [AW-1:0] wb_waddr,
   input  logic [DW-1:0] wb_wdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_pc,
   output logic [DW-1:0] out_src1,
   output logic [DW-1:0] out_src2,
   output logic [AW-1:0] out_dest,
   output logic [31:0]   stall_cnt
);
   logic [1:0][AW-1:0] src_r;
   logic [1:0][DW-1:0] src_rf;
   logic [1:0][DW-1:0] src_val;
   logic [1:0]         src_hz;
   logic [1:0]         src_use;
   logic               hazard;
   logic               accept;
   logic [SCW-1:0]     cnt;

   assign rf_raddr1 = in_rs;
   assign rf_raddr2 = in_rt;
   assign src_r     = {in_rt, in_rs};
   assign src_rf    = {rf_rdata2, rf_rdata1};
   assign src_use   = {in_use_rt, in_use_rs};

   for (genvar i = 0; i < 2; i++) begin : g_src
      id_operand_resolve #(.DW(DW), .AW(AW)) u_res (
         .r            (src_r[i]),
         .rf_rdata     (src_rf[i]),
         .ex_fwd_valid (ex_fwd_valid),
         .ex_fwd_addr  (ex_fwd_addr),
         .ex_fwd_ok    (ex_fwd_ok),
         .ex_fwd_data  (ex_fwd_data),
         .mem_fwd_valid(mem_fwd_valid),
         .mem_fwd_addr (mem_fwd_addr),
         .mem_fwd_ok   (mem_fwd_ok),
         .mem_fwd_data (mem_fwd_data),
         .wb_we        (wb_we),
         .wb_waddr     (wb_waddr),
         .wb_wdata     (wb_wdata),
         .val          (src_val[i]),
         .hz           (src_hz[i])
      );
   end

   // Unused operands never stall; in_ready must not depend on in_valid.
   assign hazard    = |(src_use & src_hz);
   assign in_ready  = !flush && !hazard && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign stall_cnt = 32'(cnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_src1  <= '0;
         out_src2  <= '0;
         out_dest  <= '0;
         cnt       <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_src1  <= src_val[0];
            out_src2  <= src_val[1];
            out_dest  <= in_dest;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (in_valid && hazard && !flush && !(&cnt))
            cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_id_operand_stage.sv
// Random + directed bench for id_operand_stage against a cycle-level model.
module tb_id_operand_stage;
   logic        clk = 0, reset = 1, flush = 0, in_valid = 0;
   logic [31:0] in_pc = 0, rf_rdata1 = 0, rf_rdata2 = 0;
   logic [4:0]  in_rs = 0, in_rt = 0, in_dest = 0;
   logic        in_use_rs = 0, in_use_rt = 0;
   logic        ex_fwd_valid = 0, ex_fwd_ok = 0, mem_fwd_valid = 0, mem_fwd_ok = 0, wb_we = 0;
   logic [4:0]  ex_fwd_addr = 0, mem_fwd_addr = 0, wb_waddr = 0;
   logic [31:0] ex_fwd_data = 0, mem_fwd_data = 0, wb_wdata = 0;
   logic        out_ready = 0;

   logic        in_ready, out_valid, in_ready2, out_valid2;
   logic [4:0]  rf_raddr1, rf_raddr2, out_dest, ra1_2, ra2_2, out_dest2;
   logic [31:0] out_pc, out_src1, out_src2, stall_cnt;
   logic [31:0] out_pc2, out_src1_2, out_src2_2, stall_cnt2;

   int nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   id_operand_stage #(.DW(32), .AW(5)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
      .in_dest(in_dest), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .ex_fwd_valid(ex_fwd_valid), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_ok(ex_fwd_ok), .ex_fwd_data(ex_fwd_data),
      .mem_fwd_valid(mem_fwd_valid), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_ok(mem_fwd_ok), .mem_fwd_data(mem_fwd_data),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_src1(out_src1),
      .out_src2(out_src2), .out_dest(out_dest), .stall_cnt(stall_cnt)
   );

   // Narrow-counter copy so saturation is reachable in a short run.
   id_operand_stage #(.DW(32), .AW(5), .SCW(2)) dut_sat (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
      .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
      .in_dest(in_dest), .rf_raddr1(ra1_2), .rf_raddr2(ra2_2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .ex_fwd_valid(ex_fwd_valid), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_ok(ex_fwd_ok), .ex_fwd_data(ex_fwd_data),
      .mem_fwd_valid(mem_fwd_valid), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_ok(mem_fwd_ok), .mem_fwd_data(mem_fwd_data),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .out_valid(out_valid2), .out_ready(out_ready), .out_pc(out_pc2), .out_src1(out_src1_2),
      .out_src2(out_src2_2), .out_dest(out_dest2), .stall_cnt(stall_cnt2)
   );

   // Model state
   logic        m_valid;
   logic [31:0] m_pc, m_s1, m_s2;
   logic [4:0]  m_dest;
   longint      m_stalls;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void resolve(input logic [4:0] r, input logic [31:0] rf,
                                   output logic [31:0] v, output logic hz);
      v = rf; hz = 0;
      if (r == 0) v = 0;
      else if (ex_fwd_valid && ex_fwd_addr == r) begin v = ex_fwd_data; hz = !ex_fwd_ok; end
      else if (mem_fwd_valid && mem_fwd_addr == r) begin v = mem_fwd_data; hz = !mem_fwd_ok; end
      else if (wb_we && wb_waddr == r) v = wb_wdata;
   endfunction

   // One cycle: compare at negedge, then advance the model at the posedge.
   task automatic step();
      logic [31:0] v1, v2;
      logic h1, h2, hz, rdy;
      #4;
      resolve(in_rs, rf_rdata1, v1, h1);
      resolve(in_rt, rf_rdata2, v2, h2);
      hz  = (in_use_rs && h1) || (in_use_rt && h2);
      rdy = !flush && !hz && (!m_valid || out_ready);
      chk("rf_raddr1", rf_raddr1, in_rs);
      chk("rf_raddr2", rf_raddr2, in_rt);
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, m_valid);
      chk("out_pc", out_pc, m_pc);
      chk("out_src1", out_src1, m_s1);
      chk("out_src2", out_src2, m_s2);
      chk("out_dest", out_dest, m_dest);
      chk("stall_cnt", stall_cnt, (m_stalls > 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_stalls);
      chk("stall_cnt_sat", stall_cnt2, (m_stalls > 3) ? 3 : m_stalls);
      @(posedge clk);
      if (reset) begin
         m_valid = 0; m_pc = 0; m_s1 = 0; m_s2 = 0; m_dest = 0; m_stalls = 0;
      end else begin
         if (in_valid && hz && !flush) m_stalls++;
         if (flush) m_valid = 0;
         else if (in_valid && rdy) begin
            m_valid = 1; m_pc = in_pc; m_s1 = v1; m_s2 = v2; m_dest = in_dest;
         end else if (out_ready) m_valid = 0;
      end
      #1;
   endtask

   task automatic no_fwd();
      ex_fwd_valid = 0; mem_fwd_valid = 0; wb_we = 0;
   endtask

   initial begin
      m_valid = 0; m_pc = 0; m_s1 = 0; m_s2 = 0; m_dest = 0; m_stalls = 0;
      #1;
      reset = 1; step(); step();
      reset = 0;
      chk("lit_reset_valid", out_valid, 0);
      chk("lit_reset_cnt", stall_cnt, 0);

      // Plain regfile read
      in_valid = 1; in_pc = 32'h100; in_rs = 3; in_rt = 4; in_use_rs = 1; in_use_rt = 1;
      in_dest = 9; rf_rdata1 = 32'h11; rf_rdata2 = 32'h22; out_ready = 1;
      step();
      chk("lit_rf_valid", out_valid, 1);
      chk("lit_rf_src1", out_src1, 32'h11);
      chk("lit_rf_src2", out_src2, 32'h22);
      chk("lit_rf_cnt", stall_cnt, 0);

      // Bypass priority EX > MEM > WB > RF
      in_rs = 5; in_rt = 5; rf_rdata1 = 32'hDDDD; rf_rdata2 = 32'hDDDD;
      ex_fwd_valid = 1; ex_fwd_addr = 5; ex_fwd_ok = 1; ex_fwd_data = 32'hAAAA;
      mem_fwd_valid = 1; mem_fwd_addr = 5; mem_fwd_ok = 1; mem_fwd_data = 32'hBBBB;
      wb_we = 1; wb_waddr = 5; wb_wdata = 32'hCCCC;
      step();
      chk("lit_ex_src1", out_src1, 32'hAAAA);
      chk("lit_ex_src2", out_src2, 32'hAAAA);
      ex_fwd_valid = 0; step();
      chk("lit_mem_src1", out_src1, 32'hBBBB);
      mem_fwd_valid = 0; step();
      chk("lit_wb_src1", out_src1, 32'hCCCC);
      no_fwd();

      // Load-use stall
      in_rs = 7; in_rt = 0; in_use_rs = 1; in_use_rt = 0;
      ex_fwd_valid = 1; ex_fwd_addr = 7; ex_fwd_ok = 0; ex_fwd_data = 32'h1234;
      step(); step(); step();
      chk("lit_lu_ready", in_ready, 0);
      chk("lit_lu_cnt", stall_cnt, 3);
      ex_fwd_ok = 1; step();
      chk("lit_lu_src1", out_src1, 32'h1234);
      ex_fwd_ok = 0; in_use_rs = 0; step();
      chk("lit_nouse_cnt", stall_cnt, 3);
      chk("lit_nouse_valid", out_valid, 1);

      // Register zero ignores bypass
      in_rs = 0; in_use_rs = 1; ex_fwd_addr = 0; ex_fwd_data = 32'hFFFF;
      step();
      chk("lit_r0_src1", out_src1, 0);
      chk("lit_r0_cnt", stall_cnt, 3);
      no_fwd();

      // Backpressure
      out_ready = 0; in_rs = 3; rf_rdata1 = 32'h55; in_pc = 32'h200;
      repeat (4) step();
      chk("lit_bp_ready", in_ready, 0);
      chk("lit_bp_src1", out_src1, 0);
      chk("lit_bp_valid", out_valid, 1);
      out_ready = 1; step();
      chk("lit_bp_load", out_src1, 32'h55);

      // Flush, then reset over a held output
      flush = 1; in_pc = 32'h300; step();
      chk("lit_flush_valid", out_valid, 0);
      flush = 0; out_ready = 0; step(); step();
      reset = 1; step();
      chk("lit_rst_valid", out_valid, 0);
      chk("lit_rst_pc", out_pc, 0);
      chk("lit_rst_src1", out_src1, 0);
      reset = 0;

      // Counter saturation on the narrow instance
      in_rs = 7; in_use_rs = 1; ex_fwd_valid = 1; ex_fwd_addr = 7; ex_fwd_ok = 0;
      repeat (5) step();
      chk("lit_sat_narrow", stall_cnt2, 3);
      chk("lit_sat_wide", stall_cnt, 5);
      no_fwd();

      // Random traffic, small register range to force collisions
      for (int i = 0; i < 3000; i++) begin
         reset         = ($urandom_range(0, 199) == 0);
         flush         = ($urandom_range(0, 19) == 0);
         in_valid      = ($urandom_range(0, 3) != 0);
         in_pc         = $urandom;
         in_rs         = 5'($urandom_range(0, 7));
         in_rt         = 5'($urandom_range(0, 7));
         in_use_rs     = $urandom_range(0, 1);
         in_use_rt     = $urandom_range(0, 1);
         in_dest       = 5'($urandom);
         rf_rdata1     = $urandom;
         rf_rdata2     = $urandom;
         ex_fwd_valid  = $urandom_range(0, 1);
         ex_fwd_addr   = 5'($urandom_range(0, 7));
         ex_fwd_ok     = ($urandom_range(0, 3) != 0);
         ex_fwd_data   = $urandom;
         mem_fwd_valid = $urandom_range(0, 1);
         mem_fwd_addr  = 5'($urandom_range(0, 7));
         mem_fwd_ok    = ($urandom_range(0, 3) != 0);
         mem_fwd_data  = $urandom;
         wb_we         = $urandom_range(0, 1);
         wb_waddr      = 5'($urandom_range(0, 7));
         wb_wdata      = $urandom;
         out_ready     = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
